// File: rtl/uart_csr_intc.sv
// 16550-class UART register file: bus decode, divisor/baud generator, line status,
// character-timeout detection and the prioritised interrupt identification logic.
module uart_csr_intc #(
    parameter int DIV_W         = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_i,
    input  logic                          rd_i,
    input  logic [2:0]                    addr_i,
    input  logic [7:0]                    din_i,
    output logic [7:0]                    dout_o,
    output logic                          tx_push_o,
    output logic                          rx_pop_o,
    input  logic [7:0]                    rx_fifo_in,
    input  logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count_i,
    input  logic                          rx_push_i,
    input  logic                          rx_fifo_empty_i,
    input  logic                          tx_fifo_empty_i,
    input  logic                          tsr_empty_i,
    input  logic                          rx_oe_i,
    input  logic                          rx_pe_i,
    input  logic                          rx_fe_i,
    input  logic                          rx_bi_i,
    output logic                          baud_o,
    output logic                          tx_fifo_rst_o,
    output logic                          rx_fifo_rst_o,
    output logic [7:0]                    lcr_o,
    output logic                          fifo_en_o,
    output logic                          irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [3:0]       ier_q;
    logic             fcr_en_q;
    logic [1:0]       fcr_trig_q;
    logic [7:0]       lcr_q;
    logic [4:0]       mcr_q;
    logic [7:0]       scr_q;
    logic [DIV_W-1:0] dl_q, dl_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d;
    logic             baud_q, baud_d;
    logic [3:0]       err_q, err_d;
    logic             lsr7_q, lsr7_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             cti_q, cti_d;
    logic             thre_q, thre_d;
    logic             tx_empty_prev_q;
    logic [7:0]       dout_q, dout_d;
    logic             irq_q;
    logic             tx_rst_q, rx_rst_q;

    logic       dlab;
    logic       wr_thr, wr_dll, wr_ier, wr_dlm, wr_fcr, wr_lcr, wr_mcr, wr_scr;
    logic       rd_rbr, rd_iir, rd_lsr;
    logic       dl_wr;
    logic [CW-1:0] trig;
    logic [3:0] iir_code;
    logic [7:0] iir, lsr, dlm_rd, rdata;

    assign dlab   = lcr_q[7];
    assign wr_thr = wr_i && (addr_i == 3'd0) && !dlab;
    assign wr_dll = wr_i && (addr_i == 3'd0) && dlab;
    assign wr_ier = wr_i && (addr_i == 3'd1) && !dlab;
    assign wr_dlm = wr_i && (addr_i == 3'd1) && dlab;
    assign wr_fcr = wr_i && (addr_i == 3'd2);
    assign wr_lcr = wr_i && (addr_i == 3'd3);
    assign wr_mcr = wr_i && (addr_i == 3'd4);
    assign wr_scr = wr_i && (addr_i == 3'd7);
    assign rd_rbr = rd_i && (addr_i == 3'd0) && !dlab;
    assign rd_iir = rd_i && (addr_i == 3'd2);
    assign rd_lsr = rd_i && (addr_i == 3'd5);
    assign dl_wr  = wr_dll || wr_dlm;

    assign tx_push_o     = wr_thr;
    assign rx_pop_o      = rd_rbr;
    assign dout_o        = dout_q;
    assign baud_o        = baud_q;
    assign tx_fifo_rst_o = tx_rst_q;
    assign rx_fifo_rst_o = rx_rst_q;
    assign lcr_o         = lcr_q;
    assign fifo_en_o     = fcr_en_q;
    assign irq_o         = irq_q;

    // Divisor latch and baud down-counter; a DL write restarts the count without a tick.
    always_comb begin
        dl_d = dl_q;
        if (wr_dll) dl_d[7:0] = din_i;
        if (wr_dlm) dl_d[DIV_W-1:8] = din_i[DIV_W-9:0];
    end

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        baud_d     = 1'b0;
        if (dl_wr) begin
            baud_cnt_d = (dl_d == '0) ? 16'd0 : 16'(dl_d) - 16'd1;
        end else if (dl_q != '0) begin
            if (baud_cnt_q == 16'd0) begin
                baud_d     = 1'b1;
                baud_cnt_d = 16'(dl_q) - 16'd1;
            end else begin
                baud_cnt_d = baud_cnt_q - 16'd1;
            end
        end
    end

    always_comb begin
        trig = CW'(1);
        if (fcr_en_q) begin
            case (fcr_trig_q)
                2'b00:   trig = CW'(1);
                2'b01:   trig = CW'(FIFO_DEPTH / 4);
                2'b10:   trig = CW'(FIFO_DEPTH / 2);
                default: trig = CW'(FIFO_DEPTH - 2);
            endcase
        end
    end

    // err_q bit order is {BI, FE, PE, OE}, matching LSR[4:1].
    assign lsr = {lsr7_q, tx_fifo_empty_i & tsr_empty_i, tx_fifo_empty_i, err_q, ~rx_fifo_empty_i};

    always_comb begin
        err_d  = (rd_lsr ? 4'b0 : err_q) | {rx_bi_i, rx_fe_i, rx_pe_i, rx_oe_i};
        lsr7_d = (rd_lsr ? 1'b0 : lsr7_q) | rx_pe_i | rx_fe_i | rx_bi_i;
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rx_push_i || rd_rbr || rx_fifo_empty_i) begin
            to_cnt_d = '0;
        end else if (baud_q && (to_cnt_q != TW'(TIMEOUT_TICKS))) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        cti_d = cti_q;
        if (rd_rbr || rx_push_i) begin
            cti_d = 1'b0;
        end else if ((to_cnt_q == TW'(TIMEOUT_TICKS)) && !rx_fifo_empty_i) begin
            cti_d = 1'b1;
        end
    end

    always_comb begin
        if (ier_q[2] && (err_q != 4'b0))              iir_code = 4'h6;
        else if (ier_q[0] && (rx_fifo_count_i >= trig)) iir_code = 4'h4;
        else if (ier_q[0] && cti_q)                   iir_code = 4'hC;
        else if (ier_q[1] && thre_q)                  iir_code = 4'h2;
        else                                          iir_code = 4'h1;
    end

    assign iir = {{2{fcr_en_q}}, 2'b00, iir_code};

    // Clears are applied after sets, so a same-cycle clear always wins.
    always_comb begin
        thre_d = thre_q;
        if ((tx_fifo_empty_i && !tx_empty_prev_q) ||
            (wr_ier && din_i[1] && !ier_q[1] && tx_fifo_empty_i)) begin
            thre_d = 1'b1;
        end
        if (wr_thr || (rd_iir && (iir_code == 4'h2))) begin
            thre_d = 1'b0;
        end
    end

    always_comb begin
        dlm_rd = 8'h00;
        dlm_rd[DIV_W-9:0] = dl_q[DIV_W-1:8];
        case (addr_i)
            3'd0:    rdata = dlab ? dl_q[7:0] : rx_fifo_in;
            3'd1:    rdata = dlab ? dlm_rd : {4'b0, ier_q};
            3'd2:    rdata = iir;
            3'd3:    rdata = lcr_q;
            3'd4:    rdata = {3'b0, mcr_q};
            3'd5:    rdata = lsr;
            3'd6:    rdata = 8'h00;
            default: rdata = scr_q;
        endcase
        dout_d = rd_i ? rdata : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier_q           <= 4'b0;
            fcr_en_q        <= 1'b0;
            fcr_trig_q      <= 2'b0;
            lcr_q           <= 8'h00;
            mcr_q           <= 5'b0;
            scr_q           <= 8'h00;
            dl_q            <= '0;
            baud_cnt_q      <= 16'd0;
            baud_q          <= 1'b0;
            err_q           <= 4'b0;
            lsr7_q          <= 1'b0;
            to_cnt_q        <= '0;
            cti_q           <= 1'b0;
            thre_q          <= 1'b0;
            tx_empty_prev_q <= 1'b1;
            dout_q          <= 8'h00;
            irq_q           <= 1'b0;
            tx_rst_q        <= 1'b0;
            rx_rst_q        <= 1'b0;
        end else begin
            if (wr_ier) ier_q <= din_i[3:0];
            if (wr_fcr) begin
                fcr_en_q   <= din_i[0];
                fcr_trig_q <= din_i[7:6];
            end
            if (wr_lcr) lcr_q <= din_i;
            if (wr_mcr) mcr_q <= din_i[4:0];
            if (wr_scr) scr_q <= din_i;
            rx_rst_q        <= wr_fcr && din_i[1];
            tx_rst_q        <= wr_fcr && din_i[2];
            dl_q            <= dl_d;
            baud_cnt_q      <= baud_cnt_d;
            baud_q          <= baud_d;
            err_q           <= err_d;
            lsr7_q          <= lsr7_d;
            to_cnt_q        <= to_cnt_d;
            cti_q           <= cti_d;
            thre_q          <= thre_d;
            tx_empty_prev_q <= tx_fifo_empty_i;
            dout_q          <= dout_d;
            irq_q           <= ~iir_code[0];
        end
    end

endmodule
